fft_r2_ctrl: RTL and testbench

Sequencing controller for the radix-2 FFT datapath: the four N/2-deep result BRAMs (x0/x1, re/im), the source-select muxes, the butterfly unit and the FFT-ready output demux. Runs three phases per transform. LOAD writes input samples into the BRAMs. COMPUTE performs LOG2N in-place butterfly stages. DRAIN streams results out. Drives all datapath control pins. The datapath's BRAMs are clocked on ~clk, so an address presented at a rising edge returns read data, or commits a write, before the next rising edge.

---
 rtl/fft_r2_ctrl.sv | 137 +++++++++++++
 tb/tb_fft_r2_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_ctrl.sv
// Sequencing controller for the radix-2 FFT datapath: load samples, run the
// in-place butterfly stages, then stream results out through the output demux.
module fft_r2_ctrl #(
  parameter int LOG2N  = 10,
  parameter int ADDR_W = LOG2N - 1,
  parameter int BF_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] tw_addr_o,
  output logic              src_sel_o,
  output logic              bram_we_o,
  output logic              bf_ce_o,
  output logic              fft_ready_o,
  output logic [3:0]        stage_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LAT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [ADDR_W-1:0] K_LAST     = {ADDR_W{1'b1}};
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(BF_LAT - 1);
  localparam logic [3:0]        STAGE_LAST = 4'(LOG2N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD, S_BF, S_WR, S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  k_q, k_d;
  logic [3:0]         stage_q, stage_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               fft_ready_q, fft_ready_d;
  logic               compute;
  logic [ADDR_W-1:0]  tw_mask;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          k_d     = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          if (k_q == K_LAST) begin
            state_d = S_RD;
            k_d     = '0;
            stage_d = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_RD: begin
        state_d = S_BF;
        lat_d   = '0;
      end
      S_BF: begin
        if (lat_q == LAT_LAST) state_d = S_WR;
        else                   lat_d   = lat_q + 1'b1;
      end
      S_WR: begin
        if (k_q != K_LAST) begin
          k_d     = k_q + 1'b1;
          state_d = S_RD;
        end else if (stage_q != STAGE_LAST) begin
          stage_d = stage_q + 1'b1;
          k_d     = '0;
          state_d = S_RD;
        end else begin
          k_d     = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (k_q == K_LAST) begin
            state_d = S_IDLE;
            k_d     = '0;
            stage_d = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Demux points at the output port whenever the butterfly is not in use.
    fft_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      stage_q     <= '0;
      lat_q       <= '0;
      fft_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      lat_q       <= lat_d;
      fft_ready_q <= fft_ready_d;
    end
  end

  assign compute = (state_q == S_RD) || (state_q == S_BF) || (state_q == S_WR);
  // Twiddle index is k with its low `stage` bits cleared.
  assign tw_mask = {ADDR_W{1'b1}} << stage_q;

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_DRAIN);
  assign addr_o      = k_q;
  assign tw_addr_o   = compute ? (k_q & tw_mask) : '0;
  assign src_sel_o   = (state_q == S_WR);
  assign bram_we_o   = ((state_q == S_LOAD) && in_valid_i) || (state_q == S_WR);
  assign bf_ce_o     = (state_q == S_BF);
  assign fft_ready_o = fft_ready_q;
  assign stage_o     = stage_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DRAIN) && out_ready_i && (k_q == K_LAST);

endmodule

// File: tb/tb_fft_r2_ctrl.sv
// Directed bench for fft_r2_ctrl at LOG2N=3, BF_LAT=2 (N/2 = 4 butterflies per stage).
module tb_fft_r2_ctrl;

  localparam int LOG2N  = 3;
  localparam int ADDR_W = 2;
  localparam int BF_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i, in_valid_i, out_ready_i;
  logic              in_ready_o, out_valid_o, src_sel_o, bram_we_o, bf_ce_o;
  logic              fft_ready_o, busy_o, done_o;
  logic [ADDR_W-1:0] addr_o, tw_addr_o;
  logic [3:0]        stage_o;

  int total = 0;
  int bad   = 0;

  fft_r2_ctrl #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
    .addr_o(addr_o), .tw_addr_o(tw_addr_o), .src_sel_o(src_sel_o),
    .bram_we_o(bram_we_o), .bf_ce_o(bf_ce_o), .fft_ready_o(fft_ready_o),
    .stage_o(stage_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] all_outs();
    return {in_ready_o, out_valid_o, addr_o, tw_addr_o, src_sel_o, bram_we_o,
            bf_ce_o, fft_ready_o, stage_o, busy_o, done_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    total++;
    if (all_outs() !== 16'h0) begin
      bad++; $display("FAIL reset_outs got=%h exp=0000", all_outs());
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({busy_o, fft_ready_o, in_ready_o} !== 3'b010) begin
      bad++; $display("FAIL idle_state got=%b exp=010", {busy_o, fft_ready_o, in_ready_o});
    end
  endtask

  task automatic test_load();
    logic       v_pat[5]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] addr_pat[5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; #1;
    total++;
    if ({in_ready_o, busy_o, fft_ready_o, addr_o, stage_o} !== {3'b111, 2'd0, 4'd0}) begin
      bad++; $display("FAIL load_entry got=%b exp=111_00_0000",
                      {in_ready_o, busy_o, fft_ready_o, addr_o, stage_o});
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      in_valid_i = v_pat[i]; #1;
      total++;
      if (bram_we_o !== v_pat[i] || addr_o !== addr_pat[i] || src_sel_o !== 1'b0) begin
        bad++; $display("FAIL load_beat%0d we=%b addr=%0d sel=%b exp we=%b addr=%0d sel=0",
                        i, bram_we_o, addr_o, src_sel_o, v_pat[i], addr_pat[i]);
      end
    end
    @(negedge clk); in_valid_i = 1'b0; #1;
    total++;
    if ({in_ready_o, fft_ready_o, bram_we_o, bf_ce_o, addr_o, busy_o} !== {4'b0000, 2'd0, 1'b1}) begin
      bad++; $display("FAIL rd_entry got=%b exp=0000_00_1",
                      {in_ready_o, fft_ready_o, bram_we_o, bf_ce_o, addr_o, busy_o});
    end
  endtask

  // Entered at the first RD cycle; start_i is held high to show it is ignored.
  task automatic test_compute();
    int cycles = 0, ce_cnt = 0, we_cnt = 0, frdy_cnt = 0, addr_bad = 0;
    int rd_addr = -1;
    int tw_got[12];
    int tw_exp[12] = '{0, 1, 2, 3, 0, 0, 2, 2, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) tw_got[i] = -1;
    start_i = 1'b1;
    #1;
    while (!out_valid_o && cycles < 200) begin
      if (fft_ready_o) frdy_cnt++;
      if (bf_ce_o) begin
        ce_cnt++;
        if (int'(addr_o) != rd_addr) addr_bad++;
      end else if (bram_we_o) begin
        we_cnt++;
        if (int'(addr_o) != rd_addr || src_sel_o !== 1'b1) addr_bad++;
        if (stage_o < 3) tw_got[int'(stage_o) * 4 + int'(addr_o)] = int'(tw_addr_o);
      end else begin
        rd_addr = int'(addr_o);
      end
      cycles++;
      @(negedge clk); #1;
    end
    total++;
    if (cycles != 48) begin bad++; $display("FAIL compute_cycles got=%0d exp=48", cycles); end
    total++;
    if (ce_cnt != 24) begin bad++; $display("FAIL bf_ce_cycles got=%0d exp=24", ce_cnt); end
    total++;
    if (we_cnt != 12) begin bad++; $display("FAIL wr_cycles got=%0d exp=12", we_cnt); end
    total++;
    if (addr_bad != 0 || frdy_cnt != 0) begin
      bad++; $display("FAIL wr_addr_hold addr_errs=%0d fft_ready_hi=%0d exp=0/0", addr_bad, frdy_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (tw_got[i] != tw_exp[i]) begin
        bad++; $display("FAIL tw_addr stage%0d k%0d got=%0d exp=%0d", i / 4, i % 4, tw_got[i], tw_exp[i]);
      end
    end
  endtask

  // Entered at the first DRAIN cycle (negedge + #1 already passed).
  task automatic test_drain();
    logic       rdy_pat[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] addr_pat[7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    logic       done_pat[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      out_ready_i = rdy_pat[i];
      if (i == 6) start_i = 1'b0;
      #1;
      if (done_o) done_cnt++;
      total++;
      if (out_valid_o !== 1'b1 || addr_o !== addr_pat[i] || done_o !== done_pat[i] ||
          fft_ready_o !== 1'b1 || bram_we_o !== 1'b0 || stage_o !== 4'd2) begin
        bad++; $display("FAIL drain_beat%0d vld=%b addr=%0d done=%b frdy=%b we=%b stage=%0d exp 1/%0d/%b/1/0/2",
                        i, out_valid_o, addr_o, done_o, fft_ready_o, bram_we_o, stage_o,
                        addr_pat[i], done_pat[i]);
      end
    end
    @(negedge clk); out_ready_i = 1'b0; #1;
    total++;
    if ({busy_o, out_valid_o, done_o, fft_ready_o, stage_o, addr_o} !== {4'b0001, 4'd0, 2'd0}) begin
      bad++; $display("FAIL post_drain got=%b exp=0001_0000_00",
                      {busy_o, out_valid_o, done_o, fft_ready_o, stage_o, addr_o});
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_bf();
    int guard = 0;
    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; in_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    in_valid_i = 1'b0; #1;
    while (!bf_ce_o && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    total++;
    if (bf_ce_o !== 1'b1) begin bad++; $display("FAIL reach_bf got=%b exp=1", bf_ce_o); end
    rst_n = 1'b0; #1;
    total++;
    if (all_outs() !== 16'h0) begin
      bad++; $display("FAIL reset_mid_bf got=%h exp=0000", all_outs());
    end
    @(negedge clk); rst_n = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; #1;
    total++;
    if ({in_ready_o, busy_o, addr_o, stage_o} !== {2'b11, 2'd0, 4'd0}) begin
      bad++; $display("FAIL restart_load got=%b exp=11_00_0000", {in_ready_o, busy_o, addr_o, stage_o});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_drain();
    test_reset_mid_bf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
